contador_horario: RTL and testbench
===================================

# contador_horario

Time-of-day counter stage directly downstream of the clock-adjust block. It keeps hours, minutes and seconds in binary from a 1 Hz tick derived from `clk`. It accepts a one-cycle load of adjusted time from the adjust stage and presents both binary and BCD-digit outputs to the 7-segment display driver.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50_000_000, is the number of `clk` cycles per second tick; it must be ≥ 2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `run`  in  1  count enable; held low by the system while in adjust mode
- `load`  in  1  one-cycle strobe carrying adjusted time (driven by the adjust stage's `adjust` pulse)
- `load_h`  in  6  hours to load, binary
- `load_m`  in  6  minutes to load, binary
- `load_s`  in  6  seconds to load, binary
- `horas`  out  6  current hours, binary, 0–23
- `minutos`  out  6  current minutes, binary, 0–59
- `segundos`  out  6  current seconds, binary, 0–59
- `hou_tens`, `hou_units`, `min_tens`, `min_units`, `sec_tens`, `sec_units`  out  4 each  BCD digits of the current time
- `sec_pulse`  out  1  one-cycle pulse after every seconds update caused by a tick
- `midnight`  out  1  one-cycle pulse after the 23:59:59 → 00:00:00 wrap
- `load_err`  out  1  one-cycle pulse after a rejected load

## Operation
- Reset state:
  - All time registers are 0 and the prescaler is 0.
  - All BCD digits are 0.
  - `sec_pulse`, `midnight` and `load_err` are 0.
- Prescaler behaviour:
  - With `run`=1 it counts 0 … `TICKS_PER_SEC`−1 and wraps to 0.
  - The tick is asserted internally in the cycle where prescaler = `TICKS_PER_SEC`−1.
  - With `run`=0 the prescaler is forced to 0 and no tick is generated.
- Tick arithmetic:
  - `segundos` increments.
  - 59 → 0 carries into `minutos`.
  - `minutos` 59 → 0 carries into `horas`.
  - `horas` 23 → 0.
  - The full wrap 23:59:59 → 00:00:00 also asserts `midnight`.
- Load validation: a load is valid when `load_h` ≤ 23, `load_m` ≤ 59 and `load_s` ≤ 59.
  - Valid load: all three registers take the load values, the prescaler is cleared to 0, and no `sec_pulse` is produced.
  - Invalid load: the time and prescaler are unchanged, and `load_err` pulses.
- `load` has priority over a tick in the same cycle; that tick is discarded.
- `load` is honoured regardless of `run`.
- `load` held high for N cycles acts as N loads. The adjust stage only produces one-cycle strobes.
- BCD digits are combinational decodes of the binary registers (tens = value/10, units = value mod 10), so they always match `horas`/`minutos`/`segundos` in the same cycle.
- Binary arithmetic stays within 6 bits; out-of-range register values are unreachable by construction.

## Timing
- A tick or load takes effect at the clock edge ending the cycle in which it is sampled. New values are visible the following cycle (1-cycle latency).
- `sec_pulse` and `midnight` are registered. They are high for exactly the first cycle in which the updated time is visible.
- `load_err` is high for the cycle after the rejected `load`.
- The first tick after `run` rises, or after a valid load with `run`=1, lands `TICKS_PER_SEC` cycles after the prescaler starts from 0.
- `run` falling mid-second discards the partial second; counting resumes with a full second.
- Reset asserted mid-operation clears everything asynchronously. The first post-reset tick arrives `TICKS_PER_SEC` cycles after reset release with `run`=1.

## Structure
- Shared package `relogio_pkg` holds:
  - `MAX_HORA`=23, `MAX_MIN`=59, `MAX_SEG`=59.
  - A `hms_t` struct with fields h, m, s of 6 bits each.
  - A `bcd2_t` struct with fields tens, units of 4 bits each.
- One sub-module, `bin2bcd6`, converts 6-bit binary (0–63) into two BCD digits. It is instantiated three times.
- Prescaler, carry chain and load logic live in the top module.

## Test plan
All scenarios use `TICKS_PER_SEC`=4.
- Reset, then `run`=1 for 4 cycles → `segundos`=1 and `sec_pulse` high for exactly 1 cycle, with `sec_units`=1 and `sec_tens`=0.
- Load 12:34:56, then 16 cycles → time 12:35:00, `min_tens`=3, `min_units`=5, and 4 `sec_pulse`s.
- Load 23:59:59, then 4 cycles → 00:00:00 with `midnight` and `sec_pulse` both high for the same single cycle.
- Load 24:00:00, or 10:60:00 → `load_err` is a 1-cycle pulse and the time is unchanged.
- `load` of 05:00:00 coincident with a tick → result is 05:00:00, not 05:00:01, and the next tick arrives 4 cycles later.
- `run` dropped at prescaler=2, then raised → the time is frozen while `run`=0, and the next tick arrives 4 cycles after `run` rises. Reset asserted mid-count → all outputs are 0 immediately.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared time-of-day types and limits for the clock stages.
package relogio_pkg;

  localparam logic [5:0] MAX_HORA = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEG  = 6'd59;

  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } hms_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // True when every field is inside its legal range.
  function automatic logic hms_valid(input hms_t t);
    return (t.h <= MAX_HORA) && (t.m <= MAX_MIN) && (t.s <= MAX_SEG);
  endfunction

endpackage

// File: rtl/contador_horario_bin2bcd6.sv
// Two-digit BCD decode of a 6-bit binary value (0-63).
module bin2bcd6
  import relogio_pkg::*;
(
  input  logic [5:0] bin,
  output bcd2_t      bcd
);

  assign bcd.tens  = 4'(bin / 6'd10);
  assign bcd.units = 4'(bin % 6'd10);

endmodule

// File: rtl/contador_horario.sv
// Time-of-day counter: 1 Hz prescaler, h/m/s carry chain, validated load,
// binary and BCD outputs for the display driver.
module contador_horario
  import relogio_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [5:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  output logic [5:0] horas,
  output logic [5:0] minutos,
  output logic [5:0] segundos,
  output logic [3:0] hou_tens,
  output logic [3:0] hou_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       sec_pulse,
  output logic       midnight,
  output logic       load_err
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  hms_t          time_r, time_nxt_s, time_inc_s, load_val_s;
  logic [PW-1:0] presc_r, presc_nxt_s;
  logic          tick_s, load_ok_s, wrap_s;
  logic          sec_pulse_r, midnight_r, load_err_r;
  logic          sec_pulse_nxt_s, midnight_nxt_s, load_err_nxt_s;
  bcd2_t         hou_bcd_s, min_bcd_s, sec_bcd_s;

  assign load_val_s = {load_h, load_m, load_s};
  assign load_ok_s  = hms_valid(load_val_s);
  assign tick_s     = run && (presc_r == PRESC_MAX);

  // Seconds increment with carries into minutes and hours.
  always_comb begin
    time_inc_s = time_r;
    wrap_s     = 1'b0;
    if (time_r.s == MAX_SEG) begin
      time_inc_s.s = 6'd0;
      if (time_r.m == MAX_MIN) begin
        time_inc_s.m = 6'd0;
        if (time_r.h == MAX_HORA) begin
          time_inc_s.h = 6'd0;
          wrap_s       = 1'b1;
        end else begin
          time_inc_s.h = time_r.h + 6'd1;
        end
      end else begin
        time_inc_s.m = time_r.m + 6'd1;
      end
    end else begin
      time_inc_s.s = time_r.s + 6'd1;
    end
  end

  // Next state: a load (valid or not) pre-empts any tick in the same cycle.
  always_comb begin
    time_nxt_s      = time_r;
    presc_nxt_s     = presc_r;
    sec_pulse_nxt_s = 1'b0;
    midnight_nxt_s  = 1'b0;
    load_err_nxt_s  = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        time_nxt_s  = load_val_s;
        presc_nxt_s = '0;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (!run) begin
      presc_nxt_s = '0;
    end else if (tick_s) begin
      presc_nxt_s     = '0;
      time_nxt_s      = time_inc_s;
      sec_pulse_nxt_s = 1'b1;
      midnight_nxt_s  = wrap_s;
    end else begin
      presc_nxt_s = presc_r + PW'(1);
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_r      <= '0;
      presc_r     <= '0;
      sec_pulse_r <= 1'b0;
      midnight_r  <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      time_r      <= time_nxt_s;
      presc_r     <= presc_nxt_s;
      sec_pulse_r <= sec_pulse_nxt_s;
      midnight_r  <= midnight_nxt_s;
      load_err_r  <= load_err_nxt_s;
    end
  end

  bin2bcd6 u_hou (.bin(time_r.h), .bcd(hou_bcd_s));
  bin2bcd6 u_min (.bin(time_r.m), .bcd(min_bcd_s));
  bin2bcd6 u_sec (.bin(time_r.s), .bcd(sec_bcd_s));

  assign horas     = time_r.h;
  assign minutos   = time_r.m;
  assign segundos  = time_r.s;
  assign hou_tens  = hou_bcd_s.tens;
  assign hou_units = hou_bcd_s.units;
  assign min_tens  = min_bcd_s.tens;
  assign min_units = min_bcd_s.units;
  assign sec_tens  = sec_bcd_s.tens;
  assign sec_units = sec_bcd_s.units;
  assign sec_pulse = sec_pulse_r;
  assign midnight  = midnight_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_contador_horario.sv
// Bench for contador_horario: hand-written vector table for the timing corners,
// then randomized traffic against a seconds-of-day reference model.
module tb_contador_horario;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, load = 1'b0;
  logic [5:0] load_h = 6'd0, load_m = 6'd0, load_s = 6'd0;
  logic [5:0] horas, minutos, segundos;
  logic [3:0] hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units;
  logic       sec_pulse, midnight, load_err;

  int checks = 0;
  int failures = 0;

  contador_horario #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .run(run), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .horas(horas), .minutos(minutos), .segundos(segundos),
    .hou_tens(hou_tens), .hou_units(hou_units),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .sec_pulse(sec_pulse), .midnight(midnight), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit run, load;
    int lh, lm, ls;
    int eh, em, es;
    int np, nm, ne;
    bit last_p, last_m, last_e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int cyc, bit r, bit l, int lh, int lm, int ls,
                              int eh, int em, int es, int np, int nm, int ne,
                              bit lp, bit lmid, bit le);
    vec_t v;
    v.cyc = cyc; v.run = r; v.load = l; v.lh = lh; v.lm = lm; v.ls = ls;
    v.eh = eh; v.em = em; v.es = es; v.np = np; v.nm = nm; v.ne = ne;
    v.last_p = lp; v.last_m = lmid; v.last_e = le;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".horas"}, horas, h);
    chk({tag, ".minutos"}, minutos, m);
    chk({tag, ".segundos"}, segundos, s);
    chk({tag, ".bcd"}, {hou_tens, hou_units, min_tens, min_units, sec_tens, sec_units},
        {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)});
  endtask

  // Reference model: absolute seconds of day plus cycles elapsed in the current second.
  int ref_secs, ref_phase;
  bit ref_p, ref_m, ref_e;

  task automatic model_step(input bit r, input bit l, input int h, input int m, input int s);
    ref_p = 1'b0; ref_m = 1'b0; ref_e = 1'b0;
    if (l) begin
      if (h <= 23 && m <= 59 && s <= 59) begin
        ref_secs = h * 3600 + m * 60 + s;
        ref_phase = 0;
      end else begin
        ref_e = 1'b1;
      end
    end else if (r) begin
      ref_phase++;
      if (ref_phase == TPS) begin
        ref_phase = 0;
        ref_secs = (ref_secs + 1) % 86400;
        ref_p = 1'b1;
        ref_m = (ref_secs == 0);
      end
    end else begin
      ref_phase = 0;
    end
  endtask

  initial begin
    int np, nm, ne;
    int r_h, r_m, r_s;
    bit r_run, r_load;

    vecs.push_back(mk( 4, 1, 0,  0,  0,  0,   0,  0,  1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk( 1, 1, 1, 12, 34, 56,  12, 34, 56, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16, 1, 0,  0,  0,  0,  12, 35,  0, 4, 0, 0, 1, 0, 0));
    vecs.push_back(mk( 1, 1, 1, 23, 59, 59,  23, 59, 59, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 4, 1, 0,  0,  0,  0,   0,  0,  0, 1, 1, 0, 1, 1, 0));
    vecs.push_back(mk( 1, 1, 1, 24,  0,  0,   0,  0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk( 1, 1, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 0, 1, 10, 60,  0,   0,  0,  0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk( 1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 3, 1, 0,  0,  0,  0,   0,  0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 1,  5,  0,  0,   5,  0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 3, 1, 0,  0,  0,  0,   5,  0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 0,  0,  0,  0,   5,  0,  1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk( 2, 1, 0,  0,  0,  0,   5,  0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 5, 0, 0,  0,  0,  0,   5,  0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 3, 1, 0,  0,  0,  0,   5,  0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk( 1, 1, 0,  0,  0,  0,   5,  0,  2, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk( 1, 0, 1,  7,  8,  9,   7,  8,  9, 0, 0, 0, 0, 0, 0));

    #12;
    chk_time("reset", 0, 0, 0);
    chk("reset.pulses", {sec_pulse, midnight, load_err}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run = vecs[i].run; load = vecs[i].load;
      load_h = 6'(vecs[i].lh); load_m = 6'(vecs[i].lm); load_s = 6'(vecs[i].ls);
      np = 0; nm = 0; ne = 0;
      for (int c = 0; c < vecs[i].cyc; c++) begin
        @(posedge clk);
        #1;
        np += int'(sec_pulse); nm += int'(midnight); ne += int'(load_err);
        if (c == 0) begin
          load = 1'b0;
        end
      end
      chk_time($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].es);
      chk($sformatf("vec%0d.counts", i), {8'(np), 8'(nm), 8'(ne)},
          {8'(vecs[i].np), 8'(vecs[i].nm), 8'(vecs[i].ne)});
      chk($sformatf("vec%0d.last", i), {sec_pulse, midnight, load_err},
          {vecs[i].last_p, vecs[i].last_m, vecs[i].last_e});
    end

    // Asynchronous reset mid-count, then first tick a full second after release.
    run = 1'b1; load = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_time("async_reset", 0, 0, 0);
    chk("async_reset.pulses", {sec_pulse, midnight, load_err}, 3'b000);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset.no_early_tick", {segundos, sec_pulse}, {6'd0, 1'b0});
    @(posedge clk);
    #1;
    chk("post_reset.tick", {segundos, sec_pulse}, {6'd1, 1'b1});

    // Randomized traffic against the model.
    reset = 1'b1;
    #1;
    ref_secs = 0; ref_phase = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      r_run = ($urandom_range(0, 9) != 0);
      r_load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r_h = 23; r_m = 59; r_s = $urandom_range(50, 59);
      end else begin
        r_h = $urandom_range(0, 25); r_m = $urandom_range(0, 61); r_s = $urandom_range(0, 61);
      end
      run = r_run; load = r_load;
      load_h = 6'(r_h); load_m = 6'(r_m); load_s = 6'(r_s);
      @(posedge clk);
      #1;
      model_step(r_run, r_load, r_h, r_m, r_s);
      checks++;
      if ({horas, minutos, segundos, sec_pulse, midnight, load_err} !==
          {6'(ref_secs / 3600), 6'((ref_secs / 60) % 60), 6'(ref_secs % 60), ref_p, ref_m, ref_e}) begin
        failures++;
        $display("FAIL rand%0d actual=%0d:%0d:%0d p%0b m%0b e%0b expected=%0d:%0d:%0d p%0b m%0b e%0b",
                 k, horas, minutos, segundos, sec_pulse, midnight, load_err,
                 ref_secs / 3600, (ref_secs / 60) % 60, ref_secs % 60, ref_p, ref_m, ref_e);
      end
      if (k % 97 == 0) begin
        chk_time($sformatf("rand%0d", k), ref_secs / 3600, (ref_secs / 60) % 60, ref_secs % 60);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
